// File: rtl/ex_forward_ctrl_if.sv
// Decode-to-forwarding-control signal bundle: decode instruction fields in,
// load-use stall and registered EX operand-mux selects out.
interface ex_forward_ctrl_if #(
    parameter int unsigned REG_W = 5
) ();
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             stall;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_reg_write, id_mem_read, flush,
        input  stall, ex_fwd_a, ex_fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_reg_write, id_mem_read, flush,
        output stall, ex_fwd_a, ex_fwd_b
    );
endinterface

// File: rtl/ex_forward_ctrl.sv
// Tracks destinations of instructions in EX and MEM, produces registered operand-forwarding
// selects for the instruction entering EX and a combinational load-use stall.
module ex_forward_ctrl #(
    parameter int unsigned REG_W = 5
) (
    input logic              clk,
    input logic              rst_n,
    ex_forward_ctrl_if.slave bus
);
    logic             ex_valid_q;
    logic             ex_wr_q;
    logic             ex_mr_q;
    logic [REG_W-1:0] ex_rd_q;
    logic             mem_valid_q;
    logic             mem_wr_q;
    logic [REG_W-1:0] mem_rd_q;
    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_b_q;
    logic [1:0]       fwd_a_d;
    logic [1:0]       fwd_b_d;
    logic             ex_prod;
    logic             mem_prod;
    logic             stall;
    logic             accept;

    // Youngest producer wins: EX slot (01) before MEM slot (10).
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             used,
        input logic             ex_p,
        input logic [REG_W-1:0] ex_rd,
        input logic             mem_p,
        input logic [REG_W-1:0] mem_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (src != '0)) begin
            if (ex_p && (ex_rd == src)) begin
                sel = 2'b01;
            end else if (mem_p && (mem_rd == src)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        ex_prod  = ex_valid_q && ex_wr_q && (ex_rd_q != '0);
        mem_prod = mem_valid_q && mem_wr_q && (mem_rd_q != '0);
        stall    = bus.id_valid && !bus.flush && ex_prod && ex_mr_q &&
                   ((bus.id_rs1_used && (bus.id_rs1 == ex_rd_q)) ||
                    (bus.id_rs2_used && (bus.id_rs2 == ex_rd_q)));
        accept   = bus.id_valid && !stall && !bus.flush;
        fwd_a_d  = 2'b00;
        fwd_b_d  = 2'b00;
        if (accept) begin
            fwd_a_d = fwd_sel(bus.id_rs1, bus.id_rs1_used, ex_prod, ex_rd_q, mem_prod, mem_rd_q);
            fwd_b_d = fwd_sel(bus.id_rs2, bus.id_rs2_used, ex_prod, ex_rd_q, mem_prod, mem_rd_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
        end else begin
            mem_valid_q <= ex_valid_q;
            mem_wr_q    <= ex_wr_q;
            mem_rd_q    <= ex_rd_q;
            // A rejected decode slot becomes a bubble; its other fields are don't-care.
            ex_valid_q  <= accept;
            ex_wr_q     <= bus.id_reg_write;
            ex_mr_q     <= bus.id_mem_read;
            ex_rd_q     <= bus.id_rd;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
        end
    end

    assign bus.stall    = stall;
    assign bus.ex_fwd_a = fwd_a_q;
    assign bus.ex_fwd_b = fwd_b_q;
endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Directed bench for ex_forward_ctrl: a history-list model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_ex_forward_ctrl;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic last_stall;

    ex_forward_ctrl_if #(.REG_W(5)) bus ();

    ex_forward_ctrl #(.REG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit mr;
    } ent_t;

    // hist[0] = instruction that entered EX last cycle, hist[1] = the one before.
    ent_t hist[$];
    int   m_fwd_a;
    int   m_fwd_b;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_producer(input ent_t e);
        return e.valid && e.wr && (e.rd != 0);
    endfunction

    function automatic int model_sel(input int src, input bit used);
        if (!used || src == 0) return 0;
        for (int i = 0; i < hist.size(); i++) begin
            if (is_producer(hist[i]) && hist[i].rd == src) return i + 1;
        end
        return 0;
    endfunction

    function automatic bit model_stall();
        if (!bus.id_valid || bus.flush || hist.size() == 0) return 1'b0;
        if (!is_producer(hist[0]) || !hist[0].mr) return 1'b0;
        return (bus.id_rs1_used && int'(bus.id_rs1) == hist[0].rd) ||
               (bus.id_rs2_used && int'(bus.id_rs2) == hist[0].rd);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_fwd_a = 0;
            m_fwd_b = 0;
        end else begin
            ent_t e;
            bit   acc;
            acc = bus.id_valid && !bus.flush && !model_stall();
            m_fwd_a = acc ? model_sel(int'(bus.id_rs1), bus.id_rs1_used) : 0;
            m_fwd_b = acc ? model_sel(int'(bus.id_rs2), bus.id_rs2_used) : 0;
            e.valid = acc;
            e.rd    = int'(bus.id_rd);
            e.wr    = bus.id_reg_write;
            e.mr    = bus.id_mem_read;
            hist.push_front(e);
            if (hist.size() > 2) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        chk("model_stall", int'(bus.stall), int'(model_stall()));
        chk("model_fwd_a", int'(bus.ex_fwd_a), m_fwd_a);
        chk("model_fwd_b", int'(bus.ex_fwd_b), m_fwd_b);
    end

    // Present one decode slot for a cycle; last_stall captures stall before the edge.
    task automatic issue(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wr, input bit mr, input bit fl);
        bus.id_valid     = v;
        bus.id_rs1       = 5'(rs1);
        bus.id_rs1_used  = u1;
        bus.id_rs2       = 5'(rs2);
        bus.id_rs2_used  = u2;
        bus.id_rd        = 5'(rd);
        bus.id_reg_write = wr;
        bus.id_mem_read  = mr;
        bus.flush        = fl;
        #1;
        last_stall = bus.stall;
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        issue(1, rs1, 1, rs2, 1, rd, 1, 0, 0);
    endtask

    task automatic load(input int rd, input int rs1);
        issue(1, rs1, 1, 0, 0, rd, 1, 1, 0);
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush_cycles(input int n);
        for (int i = 0; i < n; i++) nop();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        // Arbitrary load-use-looking inputs while in reset.
        bus.id_valid = 1; bus.id_rs1 = 4; bus.id_rs1_used = 1; bus.id_rs2 = 4;
        bus.id_rs2_used = 1; bus.id_rd = 4; bus.id_reg_write = 1; bus.id_mem_read = 1;
        bus.flush = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_stall", int'(bus.stall), 0);
        chk("reset_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("reset_fwd_b", int'(bus.ex_fwd_b), 0);
        @(negedge clk);
        nop();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add x3,x1,x2 with no producers
        alu(3, 1, 2);
        chk("first_add_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("first_add_fwd_b", int'(bus.ex_fwd_b), 0);
        flush_cycles(2);

        // add x5; sub x6,x5,x5
        alu(5, 1, 2);
        alu(6, 5, 5);
        chk("exmem_fwd_a", int'(bus.ex_fwd_a), 1);
        chk("exmem_fwd_b", int'(bus.ex_fwd_b), 1);
        flush_cycles(2);

        // add x5; nop; or x7,x5,x1
        alu(5, 1, 2);
        nop();
        alu(7, 5, 1);
        chk("memwb_fwd_a", int'(bus.ex_fwd_a), 2);
        chk("memwb_fwd_b", int'(bus.ex_fwd_b), 0);
        flush_cycles(2);

        // add x5; add x5; and x8,x5,x0
        alu(5, 1, 2);
        alu(5, 3, 4);
        alu(8, 5, 0);
        chk("prio_fwd_a", int'(bus.ex_fwd_a), 1);
        chk("prio_fwd_b_x0", int'(bus.ex_fwd_b), 0);
        flush_cycles(2);

        // lw x4; add x9,x4,x2 -> one stall, bubble, then add with A=10
        load(4, 1);
        alu(9, 4, 2);
        chk("lu_stall", int'(last_stall), 1);
        chk("lu_bubble_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("lu_bubble_fwd_b", int'(bus.ex_fwd_b), 0);
        alu(9, 4, 2);
        chk("lu_stall_once", int'(last_stall), 0);
        chk("lu_fwd_a", int'(bus.ex_fwd_a), 2);
        chk("lu_fwd_b", int'(bus.ex_fwd_b), 0);
        flush_cycles(2);

        // Producer writes x0 (as a load too); consumer reads x0
        load(0, 1);
        alu(10, 0, 0);
        chk("x0_no_stall", int'(last_stall), 0);
        chk("x0_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("x0_fwd_b", int'(bus.ex_fwd_b), 0);
        flush_cycles(2);

        // lw x4; rs2=4 but unused
        load(4, 1);
        issue(1, 1, 1, 4, 0, 11, 1, 0, 0);
        chk("unused_no_stall", int'(last_stall), 0);
        chk("unused_fwd_b", int'(bus.ex_fwd_b), 0);
        flush_cycles(2);

        // lw x4; add x9,x4,x2 with flush
        load(4, 1);
        issue(1, 4, 1, 2, 1, 9, 1, 0, 1);
        chk("flush_no_stall", int'(last_stall), 0);
        chk("flush_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("flush_fwd_b", int'(bus.ex_fwd_b), 0);
        flush_cycles(2);

        // Both operands forward from different stages: A=01 (x12), B=10 (x11)
        alu(11, 1, 2);
        alu(12, 1, 2);
        alu(13, 12, 11);
        chk("mixed_fwd_a", int'(bus.ex_fwd_a), 1);
        chk("mixed_fwd_b", int'(bus.ex_fwd_b), 2);
        flush_cycles(2);

        // Back-to-back dependent loads stall once each
        load(4, 1);
        load(5, 4);
        chk("b2b_stall1", int'(last_stall), 1);
        load(5, 4);
        chk("b2b_go1", int'(last_stall), 0);
        chk("b2b_fwd_a1", int'(bus.ex_fwd_a), 2);
        alu(6, 5, 0);
        chk("b2b_stall2", int'(last_stall), 1);
        alu(6, 5, 0);
        chk("b2b_go2", int'(last_stall), 0);
        chk("b2b_fwd_a2", int'(bus.ex_fwd_a), 2);
        flush_cycles(2);

        // Async reset mid-stall, between clock edges
        alu(7, 1, 2);
        load(4, 7);
        chk("pre_rst_fwd_a", int'(bus.ex_fwd_a), 1);
        bus.id_valid = 1; bus.id_rs1 = 4; bus.id_rs1_used = 1; bus.id_rs2 = 2;
        bus.id_rs2_used = 1; bus.id_rd = 9; bus.id_reg_write = 1; bus.id_mem_read = 0;
        bus.flush = 0;
        #1;
        chk("pre_rst_stall", int'(bus.stall), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", int'(bus.stall), 0);
        chk("rst_mid_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("rst_mid_fwd_b", int'(bus.ex_fwd_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Decode still presents add x9,x4,x2; x4 load was discarded
        chk("post_rst_stall", int'(bus.stall), 0);
        alu(9, 4, 2);
        chk("post_rst_fwd_a", int'(bus.ex_fwd_a), 0);
        chk("post_rst_fwd_b", int'(bus.ex_fwd_b), 0);
        flush_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
